// File: rtl/serial_mag_comparator_if.sv
// Request/result bundle for the bit-serial magnitude comparator.
// The requester uses the master modport; the comparator uses the slave modport.
interface serial_mag_comparator_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic         LT;
  logic         GT;
  logic         EQ;

  modport master (output start, A, B, input busy, done, LT, GT, EQ);
  modport slave  (input start, A, B, output busy, done, LT, GT, EQ);
endinterface

// File: rtl/serial_mag_comparator.sv
// Bit-serial N-bit unsigned magnitude comparator: one bit pair per clock, LSB first,
// through a 1-bit cascade cell whose registered outputs feed back as its cascade inputs.
module serial_mag_comparator #(
  parameter int N  = 8,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_mag_comparator_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sa_q, sa_d;
  logic [N-1:0]   sb_q, sb_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           l_q, l_d, g_q, g_d, e_q, e_d;
  logic           lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
  logic           done_q, done_d;
  logic           bit_a, bit_b, lt_n, gt_n, eq_n;

  // A later (more significant) unequal bit overrides whatever l/g held so far.
  assign bit_a = sa_q[0];
  assign bit_b = sb_q[0];
  assign lt_n  = (~bit_a & bit_b) | (l_q & (~bit_a | bit_b));
  assign gt_n  = (bit_a & ~bit_b) | (g_q & (bit_a | ~bit_b));
  assign eq_n  = e_q & ~(bit_a ^ bit_b);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    g_d     = g_q;
    e_d     = e_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.A;
          sb_d    = bus.B;
          l_d     = 1'b0;
          g_d     = 1'b0;
          e_d     = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        l_d   = lt_n;
        g_d   = gt_n;
        e_d   = eq_n;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        // Results bypass the cascade registers so partial values never reach the outputs.
        if (cnt_q == CW'(N - 1)) begin
          lt_d    = lt_n;
          gt_d    = gt_n;
          eq_d    = eq_n;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      l_q     <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      g_q     <= g_d;
      e_q     <= e_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.LT   = lt_q;
  assign bus.GT   = gt_q;
  assign bus.EQ   = eq_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed self-checking bench for serial_mag_comparator (N=8 instance plus an N=4 instance
// swept over every operand pair).
module tb_serial_mag_comparator;

  localparam logic [2:0] RES_LT = 3'b100;
  localparam logic [2:0] RES_GT = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b001;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   done_seen;

  serial_mag_comparator_if #(.N(8)) bus8 ();
  serial_mag_comparator_if #(.N(4)) bus4 ();

  serial_mag_comparator #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_mag_comparator #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus8.start = s;
    bus8.A     = a;
    bus8.B     = b;
  endtask

  // One full comparison on the N=8 instance, with operands scrambled after acceptance
  // and an optional stray start pulse in the middle of RUN.
  task automatic runCompare(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] expected, input bit mid_pulse);
    applyStimulus(1'b1, a, b);
    @(posedge clk); #1;
    checkOutput({tag, "_accept_busy"}, 32'(bus8.busy), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(mid_pulse && (i == 3), ~a, ~b);
      @(posedge clk); #1;
      if (i < 8) begin
        checkOutput({tag, "_run_busy"}, 32'(bus8.busy), 32'd1);
        checkOutput({tag, "_run_done"}, 32'(bus8.done), 32'd0);
      end else begin
        checkOutput({tag, "_done"}, 32'(bus8.done), 32'd1);
        checkOutput({tag, "_done_busy"}, 32'(bus8.busy), 32'd0);
        checkOutput({tag, "_result"}, 32'({bus8.LT, bus8.GT, bus8.EQ}), 32'(expected));
      end
    end
    applyStimulus(1'b0, ~a, ~b);
    @(posedge clk); #1;
    checkOutput({tag, "_done_drop"}, 32'(bus8.done), 32'd0);
    checkOutput({tag, "_idle_busy"}, 32'(bus8.busy), 32'd0);
    checkOutput({tag, "_held"}, 32'({bus8.LT, bus8.GT, bus8.EQ}), 32'(expected));
  endtask

  logic [7:0] b2b_a   [3];
  logic [7:0] b2b_b   [3];
  logic [7:0] junk_a  [3];
  logic [7:0] junk_b  [3];
  logic [2:0] b2b_exp [3];
  logic [2:0] ref4;

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.A     = '0;
    bus8.B     = '0;
    bus4.start = 1'b0;
    bus4.A     = '0;
    bus4.B     = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_outputs8", 32'({bus8.busy, bus8.done, bus8.LT, bus8.GT, bus8.EQ}), 32'd0);
    checkOutput("rst_outputs4", 32'({bus4.busy, bus4.done, bus4.LT, bus4.GT, bus4.EQ}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus8.done || bus8.busy) done_seen++;
    end
    checkOutput("idle_no_activity", 32'(done_seen), 32'd0);
    checkOutput("idle_outputs", 32'({bus8.LT, bus8.GT, bus8.EQ}), 32'd0);

    // Directed comparisons
    runCompare("gt_a5_5a", 8'hA5, 8'h5A, RES_GT, 1'b1);
    runCompare("eq_3c",    8'h3C, 8'h3C, RES_EQ, 1'b0);
    runCompare("lt_80_81", 8'h80, 8'h81, RES_LT, 1'b0);
    runCompare("lt_01_80", 8'h01, 8'h80, RES_LT, 1'b1);

    // Back-to-back with start held high and operands changing every cycle
    b2b_a[0] = 8'h10; b2b_b[0] = 8'h20; b2b_exp[0] = RES_LT; junk_a[0] = 8'hFF; junk_b[0] = 8'h00;
    b2b_a[1] = 8'h77; b2b_b[1] = 8'h77; b2b_exp[1] = RES_EQ; junk_a[1] = 8'h01; junk_b[1] = 8'h00;
    b2b_a[2] = 8'hC0; b2b_b[2] = 8'h3F; b2b_exp[2] = RES_GT; junk_a[2] = 8'h00; junk_b[2] = 8'hFF;
    for (int cyc = 0; cyc < 27; cyc++) begin
      if (cyc % 9 == 0) applyStimulus(1'b1, b2b_a[cyc / 9], b2b_b[cyc / 9]);
      else              applyStimulus(1'b1, junk_a[cyc / 9], junk_b[cyc / 9]);
      @(posedge clk); #1;
      if (cyc % 9 == 8) begin
        checkOutput("b2b_done", 32'(bus8.done), 32'd1);
        checkOutput("b2b_result", 32'({bus8.LT, bus8.GT, bus8.EQ}), 32'(b2b_exp[cyc / 9]));
      end else begin
        checkOutput("b2b_busy", 32'(bus8.busy), 32'd1);
        checkOutput("b2b_no_done", 32'(bus8.done), 32'd0);
      end
    end
    applyStimulus(1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    checkOutput("b2b_last_done_drop", 32'(bus8.done), 32'd0);

    // Abort in the middle of a comparison
    applyStimulus(1'b1, 8'hFF, 8'h00);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 8'hFF);
      @(posedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_immediate", 32'({bus8.busy, bus8.done, bus8.LT, bus8.GT, bus8.EQ}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.done || bus8.busy) done_seen++;
    end
    checkOutput("abort_no_done", 32'(done_seen), 32'd0);
    checkOutput("abort_outputs", 32'({bus8.LT, bus8.GT, bus8.EQ}), 32'd0);
    runCompare("after_abort_lt", 8'h00, 8'hFF, RES_LT, 1'b0);

    // Every operand pair on the N=4 instance
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ref4 = (a < b) ? RES_LT : ((a > b) ? RES_GT : RES_EQ);
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.A     = 4'(a);
        bus4.B     = 4'(b);
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.A     = ~4'(a);
        bus4.B     = ~4'(b);
        repeat (4) @(posedge clk);
        #1;
        checkOutput($sformatf("n4_done_%0d_%0d", a, b), 32'(bus4.done), 32'd1);
        checkOutput($sformatf("n4_result_%0d_%0d", a, b),
                    32'({bus4.LT, bus4.GT, bus4.EQ}), 32'(ref4));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
